fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Issues word reads to instruction memory over a valid/ready request channel and keeps PC tags in step with the responses.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode over a valid/next handshake.
- On a control flush, redirects the PC, drains the FIFO and discards any in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- c_flush  in  1  redirect request from execute; single-cycle pulse.
- c_target  in  32  new PC, sampled when c_flush=1.
- c_error  out  1  sticky fetch fault (misaligned target or bus error).
- m_req_valid  out  1  memory read request valid.
- m_req_ready  in  1  memory accepts the request.
- m_req_addr  out  32  word address (bits [1:0] always 0).
- m_rsp_valid  in  1  read data returned; in order, at least 1 cycle after acceptance.
- m_rsp_data  in  32  instruction word.
- m_rsp_err  in  1  bus error for this response.
- o_valid  out  1  instruction available to decode.
- o_next  in  1  decode consumes; a transfer occurs when o_valid & o_next.
- o_instr  out  32  instruction word.
- o_pc  out  33  {1'b1, pc}; bit 32 marks a valid PC for the decoder's PC operand.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - c_error=0, m_req_valid=0, o_valid=0, o_instr=0, o_pc=0.
- Credit rule: m_req_valid=1 only when all of the following hold:
  - outstanding + fifo_count < DEPTH;
  - drop_cnt==0;
  - c_error==0;
  - c_flush==0.
- Issue:
  - m_req_addr=pc.
  - On m_req_valid & m_req_ready: pc <= pc+4 (wraps mod 2^32), push pc into the tag queue, outstanding++.
- Response (drop_cnt==0):
  - m_rsp_err=0: push {data, tag} into the FIFO, pop the tag, outstanding--.
  - m_rsp_err=1: data not pushed, c_error <= 1, tag popped, outstanding--.
- Response (drop_cnt>0): discarded, drop_cnt--, outstanding--, tag popped.
- Counter widths:
  - outstanding and drop_cnt: $clog2(DEPTH)+1 bits.
  - The credit rule guarantees the FIFO never overflows.
- Output:
  - o_valid = FIFO non-empty & ~c_flush & ~c_error.
  - o_instr and o_pc driven from the FIFO head.
  - Pop on o_valid & o_next.
  - Simultaneous push and pop on a full FIFO is legal.
- Latency: request accepted in cycle N, response in N+1, o_valid in N+2.
- Flush (c_flush=1):
  - pc <= c_target; FIFO cleared; tag queue cleared.
  - drop_cnt <= outstanding - (m_rsp_valid ? 1 : 0); outstanding tracks the same value.
  - A response arriving in the flush cycle is discarded.
  - c_error <= 1 if c_target[1:0]!=0, else c_error <= 0.
  - No request is issued in the flush cycle; fetch resumes at c_target once drop_cnt==0.
- Error: while c_error=1, there are no new requests and o_valid=0. Outstanding responses are still absorbed and dropped. Only c_flush clears c_error.
- Decode back-pressure (o_next=0):
  - The FIFO fills, then requests stop via the credit rule.
  - No instruction is lost or duplicated.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop_cnt==0, and m_rsp_valid & ~m_rsp_err:
  - the response drives o_instr/o_pc combinationally with o_valid=1;
  - if o_next=1, the response is consumed without entering the FIFO;
  - latency becomes N+1.
- Undefined: all responses go through the FIFO; latency is N+2.

Test Plan:
- Reset, then release with m_req_ready=1 and 1-cycle memory → addresses 0,4,8,… issued back-to-back; o_valid from cycle 2; o_pc=33'h1_0000_0000, 33'h1_0000_0004, … in order.
- o_next=0 for 20 cycles → exactly DEPTH=4 requests accepted, then m_req_valid=0; release o_next → PCs 0,4,8,C delivered, no gaps or duplicates.
- 3 requests outstanding, c_flush with c_target=32'h100 → 3 stale responses dropped, the next m_req_addr is 0x100, and the first delivered o_pc is 33'h1_0000_0100.
- Flush with c_target=32'h102 → c_error=1, no requests, o_valid=0; a later flush to 32'h200 clears c_error and fetch resumes at 0x200.
- m_rsp_err=1 on the response for PC 0x8 → c_error=1, PCs 0 and 4 still delivered, PC 8 never delivered.
- FETCH_BYPASS_EN defined, empty FIFO, o_next=1 → o_valid asserts in the same cycle as m_rsp_valid.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word reads, in-order PC tag queue and a prefetch FIFO toward decode.
// Define FETCH_BYPASS_EN to let a response reach decode in the same cycle when the FIFO is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_flush,
  input  logic [31:0] c_target,
  output logic        c_error,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  input  logic        m_rsp_valid,
  input  logic [31:0] m_rsp_data,
  input  logic        m_rsp_err,
  output logic        o_valid,
  input  logic        o_next,
  output logic [31:0] o_instr,
  output logic [32:0] o_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = CW + 1;
  localparam logic [CW:0] DEPTH_W = DW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          c_error_q, c_error_d;
  logic [AW-1:0] tag_wr_q, tag_rd_q;
  logic [AW-1:0] fifo_wr_q, fifo_rd_q;
  logic [31:0]   tag_mem_q [DEPTH];
  fetch_entry_t  fifo_mem_q [DEPTH];

  logic [CW:0]  credit_used;
  logic         fifo_empty;
  logic         drop_idle;
  logic         req_fire;
  logic         rsp_live;
  logic         rsp_push;
  logic         fifo_pop;
  logic         bypass;
  logic [31:0]  tag_head;
  fetch_entry_t fifo_head;

  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign drop_idle   = (drop_cnt_q == '0);
  assign tag_head    = tag_mem_q[tag_rd_q];
  assign fifo_head   = fifo_mem_q[fifo_rd_q];

  // Reset gates the request directly so nothing is offered to memory while rst is held.
  assign m_req_valid = ~rst & (credit_used < DEPTH_W) & drop_idle & ~c_error_q & ~c_flush;
  assign m_req_addr  = pc_q;
  assign req_fire    = m_req_valid & m_req_ready;
  assign c_error     = c_error_q;

  // A live response belongs to the tag at the head of the queue; stale or flush-cycle ones do not.
  assign rsp_live = m_rsp_valid & drop_idle & ~c_flush;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty & rsp_live & ~m_rsp_err & ~c_error_q;
`else
  assign bypass = 1'b0;
`endif

  assign o_valid  = (~fifo_empty | bypass) & ~c_flush & ~c_error_q;
  assign fifo_pop = o_valid & o_next & ~bypass;
  assign rsp_push = rsp_live & ~m_rsp_err & ~c_error_q & ~(bypass & o_next);

  always_comb begin
    o_instr = '0;
    o_pc    = '0;
    if (o_valid) begin
      if (bypass) begin
        o_instr = m_rsp_data;
        o_pc    = {1'b1, tag_head};
      end else begin
        o_instr = fifo_head.instr;
        o_pc    = {1'b1, fifo_head.pc};
      end
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_cnt_d    = fifo_cnt_q;
    c_error_d     = c_error_q;
    if (c_flush) begin
      pc_d          = c_target;
      outstanding_d = outstanding_q - CW'(m_rsp_valid);
      drop_cnt_d    = outstanding_q - CW'(m_rsp_valid);
      fifo_cnt_d    = '0;
      c_error_d     = (c_target[1:0] != 2'b00);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(m_rsp_valid);
      if (m_rsp_valid && !drop_idle) drop_cnt_d = drop_cnt_q - CW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_push) - CW'(fifo_pop);
      if (rsp_live && m_rsp_err) c_error_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      c_error_q     <= 1'b0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      c_error_q     <= c_error_d;
      if (c_flush) begin
        tag_wr_q  <= '0;
        tag_rd_q  <= '0;
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (req_fire) tag_wr_q  <= tag_wr_q + AW'(1);
        if (rsp_live) tag_rd_q  <= tag_rd_q + AW'(1);
        if (rsp_push) fifo_wr_q <= fifo_wr_q + AW'(1);
        if (fifo_pop) fifo_rd_q <= fifo_rd_q + AW'(1);
      end
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and counts alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= pc_q;
    if (rsp_push) fifo_mem_q[fifo_wr_q] <= '{instr: m_rsp_data, pc: tag_head};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios, then randomized memory, decode and flush traffic
// checked against an instruction-stream model (expected PC sequence per flush epoch).
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        c_flush;
  logic [31:0] c_target;
  logic        c_error;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_req_addr;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_data;
  logic        m_rsp_err;
  logic        o_valid;
  logic        o_next;
  logic [31:0] o_instr;
  logic [32:0] o_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .c_flush(c_flush), .c_target(c_target), .c_error(c_error),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err),
    .o_valid(o_valid), .o_next(o_next), .o_instr(o_instr), .o_pc(o_pc)
  );

  typedef struct {
    logic [31:0] pc;
    int          epoch;
    bit          err;
    int          ready_at;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model_pc;
  int          epoch;
  bit          err_state;
  bit          err_clear;

  int          ready_mode;
  int          rsp_mode;
  int          next_mode;
  bit          hold_rsp;
  bit          err_pc_en;
  logic [31:0] err_pc;
  int          rand_err_pct;

  int          acc_cnt;
  int          deliv_cnt;
  int          first_acc_cyc;
  int          first_valid_cyc;
  logic [31:0] first_acc_addr;
  logic [31:0] first_deliv_pc;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    acc_cnt         = 0;
    deliv_cnt       = 0;
    first_acc_cyc   = -1;
    first_valid_cyc = -1;
    first_acc_addr  = '0;
    first_deliv_pc  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    c_flush     = 1'b0;
    c_target    = '0;
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = '0;
    m_rsp_err   = 1'b0;
    o_next      = 1'b0;
    #1;
    check("rst_m_req_valid", m_req_valid, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_c_error", c_error, 0);
    check("rst_o_pc", o_pc, 0);
    check("rst_o_instr", o_instr, 0);
    pend_q.delete();
    exp_q.delete();
    model_pc  = 32'h0;
    err_state = 1'b0;
    err_clear = 1'b0;
    epoch++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle of stimulus plus the model's view of what that cycle must do.
  task automatic step(input bit do_flush, input logic [31:0] tgt);
    bit    present;
    bit    err_start;
    bit    must_idle;
    int    stale;
    pend_t p;
    @(negedge clk);
    if (err_clear) begin
      exp_q.delete();
      err_clear = 1'b0;
    end
    stale = 0;
    foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale++;
    err_start = err_state;
    must_idle = err_state || (stale > 0);
    check("c_error", c_error, err_state);

    present = 1'b0;
    if (pend_q.size() > 0 && !hold_rsp && pend_q[0].ready_at <= cyc)
      present = (rsp_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    m_rsp_valid = present;
    m_rsp_data  = present ? mem_word(pend_q[0].pc) : 32'h0;
    m_rsp_err   = present ? pend_q[0].err : 1'b0;
    m_req_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    o_next      = (next_mode == 0) ? 1'b1 : (next_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    c_flush     = do_flush;
    c_target    = tgt;

    if (present) begin
      p = pend_q.pop_front();
      if (!do_flush && p.epoch == epoch && !err_state) begin
        if (p.err) begin
          err_state = 1'b1;
          err_clear = 1'b1;
        end else begin
          exp_q.push_back('{pc: p.pc, instr: mem_word(p.pc)});
        end
      end
    end
    if (do_flush) begin
      epoch++;
      exp_q.delete();
      err_clear = 1'b0;
      model_pc  = tgt;
      err_state = (tgt[1:0] != 2'b00);
    end

    #1;
    if (must_idle) check("req_idle", m_req_valid, 0);
    if (err_start) check("o_valid_in_error", o_valid, 0);
    if (m_req_valid && m_req_ready) begin
      check("req_addr", m_req_addr, model_pc);
      check("credit_limit", pend_q.size() < DEPTH, 1);
      if (acc_cnt == 0) begin
        first_acc_cyc  = cyc;
        first_acc_addr = m_req_addr;
      end
      acc_cnt++;
      pend_q.push_back('{pc: model_pc, epoch: epoch,
                         err: (err_pc_en && model_pc == err_pc) || (int'($urandom_range(0, 99)) < rand_err_pct),
                         ready_at: cyc + 1 + ((rsp_mode == 0) ? 0 : int'($urandom_range(0, 3)))});
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Monitor: every decode transfer must match the oldest expected instruction.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst !== 1'b1 && o_valid === 1'b1) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_next === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_transfer: got o_pc %0h, expected no transfer (cycle %0d)", o_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check("o_pc", o_pc, {1'b1, e.pc});
          check("o_instr", o_instr, e.instr);
          if (deliv_cnt == 0) first_deliv_pc = o_pc[31:0];
          deliv_cnt++;
        end
      end
    end
  end

  initial begin
    rst          = 1'b1;
    c_flush      = 1'b0;
    c_target     = '0;
    m_req_ready  = 1'b0;
    m_rsp_valid  = 1'b0;
    m_rsp_data   = '0;
    m_rsp_err    = 1'b0;
    o_next       = 1'b0;
    epoch        = 0;
    ready_mode   = 0;
    rsp_mode     = 0;
    next_mode    = 0;
    hold_rsp     = 1'b0;
    err_pc_en    = 1'b0;
    err_pc       = '0;
    rand_err_pct = 0;
    clear_stats();

    // Streaming with an always-ready, one-cycle memory.
    do_reset();
    clear_stats();
    repeat (20) step(1'b0, 32'h0);
    check("a_back_to_back", acc_cnt, 20);
    check("a_latency", first_valid_cyc - first_acc_cyc, LAT);
    check("a_first_pc", first_deliv_pc, 32'h0);

    // Decode back-pressure fills the FIFO and then stops requests.
    do_reset();
    clear_stats();
    next_mode = 2;
    repeat (20) step(1'b0, 32'h0);
    check("b_accepts", acc_cnt, DEPTH);
    check("b_req_stalled", m_req_valid, 0);
    next_mode = 0;
    repeat (12) step(1'b0, 32'h0);
    check("b_first_pc", first_deliv_pc, 32'h0);
    check("b_delivered_all", deliv_cnt >= DEPTH, 1);

    // Flush with three responses still in flight.
    do_reset();
    clear_stats();
    hold_rsp = 1'b1;
    for (int i = 0; i < 10 && acc_cnt < 3; i++) step(1'b0, 32'h0);
    check("c_accepts", acc_cnt, 3);
    step(1'b1, 32'h100);
    hold_rsp = 1'b0;
    clear_stats();
    repeat (15) step(1'b0, 32'h0);
    check("c_resume_addr", first_acc_addr, 32'h100);
    check("c_first_pc", first_deliv_pc, 32'h100);

    // Misaligned redirect is sticky until an aligned one.
    do_reset();
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h102);
    repeat (8) step(1'b0, 32'h0);
    check("d_error_set", c_error, 1);
    check("d_no_req", m_req_valid, 0);
    check("d_no_valid", o_valid, 0);
    step(1'b1, 32'h200);
    clear_stats();
    repeat (10) step(1'b0, 32'h0);
    check("d_error_clear", c_error, 0);
    check("d_resume_addr", first_acc_addr, 32'h200);
    check("d_resume_pc", first_deliv_pc, 32'h200);

    // Bus error on the response for PC 0x8.
    do_reset();
    clear_stats();
    err_pc_en = 1'b1;
    err_pc    = 32'h8;
    repeat (15) step(1'b0, 32'h0);
    check("e_delivered", deliv_cnt, 2);
    check("e_error", c_error, 1);
    err_pc_en = 1'b0;

    // Randomized traffic: ready, latency, decode stalls, flushes (some misaligned or near wrap), bus errors.
    do_reset();
    ready_mode   = 1;
    rsp_mode     = 1;
    next_mode    = 1;
    rand_err_pct = 2;
    begin
      bit          last_flush;
      bit          f;
      logic [31:0] t;
      last_flush = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        f = !last_flush && ($urandom_range(0, 39) == 0);
        case ($urandom_range(0, 7))
          0:       t = 32'hFFFF_FFF0;
          1:       t = ($urandom_range(0, 4095) << 2) | 32'd2;
          default: t = $urandom_range(0, 4095) << 2;
        endcase
        step(f, t);
        last_flush = f;
      end
    end

    // Recover and confirm the stream resumes cleanly.
    rand_err_pct = 0;
    next_mode    = 0;
    step(1'b0, 32'h0);
    step(1'b1, 32'h40);
    clear_stats();
    repeat (40) step(1'b0, 32'h0);
    check("f_recovered_error", c_error, 0);
    check("f_recovered_pc", first_deliv_pc, 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
